// File: rtl/mips_pkg.sv
// Purpose: opcode constants shared by the instruction-memory loader and the main decoder.
// Latency: none; constants and a pure combinational helper only.
// Backpressure: not applicable.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // True for every opcode the single-cycle core can execute.
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Purpose: shifts stream bytes MSB-first into a 32-bit word and flags the 4th byte.
// Latency: word register updates on the edge that accepts the byte; full is combinational.
// Backpressure: none of its own; shifts only when load is asserted by the parent.
// Ports: clk, reset (sync, active-high); load shifts byte_in in; clear empties the word
//        and byte index; word is the shift register; full marks a load that completes a word.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= {word[23:0], byte_in};
            idx  <= idx + 2'd1;   // wraps to 0 after the 4th byte, ready for the next word
        end
    end

    assign full = load && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Purpose: boot loader; takes a header byte N and N big-endian words, writes them to imem.
// Latency: write cycle directly follows the 4th byte of a word; at best one word per 5 cycles.
// Backpressure: byte_ready is a registered function of state only; low during the write cycle.
// Ports: clk, reset (sync, active-high), start; byte_in/byte_valid/byte_ready stream input;
//        imem_we/imem_addr/imem_wd memory write port; cpu_reset, done, error, count status.
// Build option: define IMEM_LOADER_OPCHK_EN to reject words whose opcode the core lacks.
module imem_loader
    import mips_pkg::*;
#(
    parameter int AW    = 6,
    parameter int WORDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [AW:0]   count
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    localparam int         CW      = AW + 1;
    localparam logic [7:0] WORDS_B = 8'(WORDS);

    state_t      state;
    logic [AW:0] n_words;
    logic [AW:0] count_inc;
    logic [31:0] asm_word;
    logic        asm_full;
    logic        asm_load;
    logic        asm_clear;
    logic        accept;
    logic        op_ok;
    logic        in_write;

    assign accept    = byte_valid && byte_ready;
    assign asm_load  = accept && (state == DATA);
    assign asm_clear = accept && (state == HDR);
    assign count_inc = count + 1'b1;
    assign in_write  = (state == WRITE);

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .load    (asm_load),
        .clear   (asm_clear),
        .byte_in (byte_in),
        .word    (asm_word),
        .full    (asm_full)
    );

`ifdef IMEM_LOADER_OPCHK_EN
    assign op_ok = op_supported(asm_word[31:26]);
`else
    assign op_ok = 1'b1;
`endif

    // The assembled word sits complete in the shift register throughout WRITE,
    // so the write port is decoded from state; zeros elsewhere keep waveforms clean.
    assign imem_we   = in_write && op_ok;
    assign imem_addr = in_write ? count[AW-1:0] : '0;
    assign imem_wd   = in_write ? asm_word : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count      <= '0;
            n_words    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= HDR;
                        byte_ready <= 1'b1;
                    end
                end
                HDR: begin
                    if (byte_valid) begin
                        if (byte_in == 8'd0) begin
                            state      <= DONE;
                            byte_ready <= 1'b0;
                            cpu_reset  <= 1'b0;
                            done       <= 1'b1;
                        end else if (byte_in > WORDS_B) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state   <= DATA;
                            n_words <= CW'(byte_in);
                            count   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (asm_full) begin
                        state      <= WRITE;
                        byte_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!op_ok) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        count <= count_inc;
                        if (count_inc == n_words) begin
                            state     <= DONE;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state      <= DATA;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        state      <= HDR;
                        byte_ready <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        count      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: randomized self-checking bench for imem_loader against a cycle-level stream model.
// Latency: model predicts each output one or two cycles after the byte/start that causes it.
// Backpressure: bench holds byte_valid until byte_ready accepts, with random idle gaps.
module tb_imem_loader;

    localparam int AW    = 6;
    localparam int WORDS = 64;
    localparam int CW    = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   count;

    imem_loader #(.AW(AW), .WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .count      (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic op_allowed(input logic [5:0] op);
`ifdef IMEM_LOADER_OPCHK_EN
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
`else
        return (op == op);
`endif
    endfunction

    // ---------------- memory as seen on the write port ----------------
    logic [31:0] dut_mem [64];
    logic [31:0] ref_mem [64];
    int          we_cnt  = 0;
    int          overlap = 0;

    always @(posedge clk) begin
        if (imem_we) begin
            dut_mem[imem_addr] <= imem_wd;
            we_cnt <= we_cnt + 1;
        end
        if (imem_we && byte_ready) overlap <= overlap + 1;
    end

    // ---------------- stream-level reference model ----------------
    typedef struct packed {
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          dn;
        logic          er;
        logic [AW:0]   cnt;
    } exp_t;

    localparam int M_IDLE = 0, M_HDR = 1, M_DATA = 2, M_BUSY = 3, M_DONE = 4, M_ERR = 5;

    exp_t        cur = '0;
    exp_t        nxt = '0;
    int          cur_ph = M_IDLE;
    int          nxt_ph = M_IDLE;
    logic        chk_en = 1'b0;
    logic [31:0] m_word = '0;
    int          m_nb = 0;
    int          m_n  = 0;
    int          m_wc = 0;
    int          st;
    logic        ok;

    // Compare outputs expected for this cycle, then fold in what the inputs
    // presented now (sampled at the coming edge) will cause.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_ready", byte_ready, cur.rdy);
            chk("imem_we",    imem_we,    cur.we);
            chk("imem_addr",  imem_addr,  cur.addr);
            chk("imem_wd",    imem_wd,    cur.wd);
            chk("done",       done,       cur.dn);
            chk("error",      error,      cur.er);
            chk("cpu_reset",  cpu_reset,  !cur.dn);
            chk("count",      count,      cur.cnt);
        end
        st     = cur_ph;
        cur    = nxt;
        cur_ph = nxt_ph;
        nxt.we = 1'b0; nxt.addr = '0; nxt.wd = '0;
        if (reset) begin
            cur = '0; nxt = '0;
            cur_ph = M_IDLE; nxt_ph = M_IDLE;
            m_nb = 0; m_word = '0;
            chk_en = 1'b1;
        end else if (start && (st == M_IDLE || st == M_DONE || st == M_ERR)) begin
            cur.rdy = 1'b1; cur.dn = 1'b0; cur.er = 1'b0; cur.cnt = '0;
            cur_ph = M_HDR;
            nxt = cur; nxt_ph = M_HDR;
        end else if (byte_valid && st == M_HDR) begin
            if (byte_in == 8'd0) begin
                cur.dn = 1'b1; cur.rdy = 1'b0; cur_ph = M_DONE;
            end else if (int'(byte_in) > WORDS) begin
                cur.er = 1'b1; cur.rdy = 1'b0; cur_ph = M_ERR;
            end else begin
                m_n = int'(byte_in); m_nb = 0; m_wc = 0; m_word = '0;
                cur.cnt = '0; cur_ph = M_DATA;
            end
            nxt = cur; nxt_ph = cur_ph;
        end else if (byte_valid && st == M_DATA) begin
            m_word = {m_word[23:0], byte_in};
            m_nb++;
            if (m_nb == 4) begin
                m_nb = 0;
                ok = op_allowed(m_word[31:26]);
                cur.rdy = 1'b0; cur.we = ok; cur.addr = AW'(m_wc); cur.wd = m_word;
                cur_ph = M_BUSY;
                nxt = cur; nxt.we = 1'b0; nxt.addr = '0; nxt.wd = '0;
                if (ok) begin
                    ref_mem[m_wc] = m_word;
                    m_wc++;
                    nxt.cnt = CW'(m_wc);
                    if (m_wc == m_n) begin
                        nxt.dn = 1'b1; nxt_ph = M_DONE;
                    end else begin
                        nxt.rdy = 1'b1; nxt_ph = M_DATA;
                    end
                end else begin
                    nxt.er = 1'b1; nxt_ph = M_ERR;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        got = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_in    = b;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (byte_ready) got = 1'b1;
        end
        chk("byte_accept", got, 1'b1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] hdr, input logic [31:0] ws[$], input int maxgap);
        logic [31:0] w;
        pulse_start();
        send_byte(hdr, $urandom_range(maxgap, 0));
        for (int i = 0; i < ws.size(); i++) begin
            w = ws[i];
            for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], $urandom_range(maxgap, 0));
        end
    endtask

    task automatic wait_end();
        logic fin;
        fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(negedge clk);
            if (done || error) fin = 1'b1;
        end
        chk("load_end", fin, 1'b1);
        tick();
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < 64; i++) if (dut_mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    function automatic logic [31:0] rand_word_ok();
        logic [5:0]  ops [6];
        logic [31:0] w;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        w = $urandom();
        w[31:26] = ops[$urandom_range(5, 0)];
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] ws[$];
        logic [31:0] snap [3];
        int          w0;
        logic [7:0]  hb;

        for (int i = 0; i < 64; i++) begin
            dut_mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_cpu_reset",  cpu_reset,  1'b1);
        chk("rst_count",      count,      '0);
        tick();

        // Two-word program, no gaps.
        w0 = we_cnt;
        ws = '{32'h20080005, 32'hAC08003C};
        send_load(8'h02, ws, 0);
        wait_end();
        chk("t1_mem0",   dut_mem[0], 32'h20080005);
        chk("t1_mem1",   dut_mem[1], 32'hAC08003C);
        chk("t1_writes", we_cnt - w0, 2);
        chk("t1_done",   done, 1'b1);
        chk("t1_cpurst", cpu_reset, 1'b0);
        chk("t1_count",  count, 7'd2);

        // Empty program: done in the cycle after the header.
        w0 = we_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("t2_done",   done, 1'b1);
        chk("t2_cpurst", cpu_reset, 1'b0);
        chk("t2_writes", we_cnt - w0, 0);
        tick();

        // Oversized header, then recovery.
        w0 = we_cnt;
        ws = {};
        send_load(8'h41, ws, 0);
        wait_end();
        chk("t3_error",  error, 1'b1);
        chk("t3_cpurst", cpu_reset, 1'b1);
        chk("t3_writes", we_cnt - w0, 0);
        ws = '{32'h00851020};
        send_load(8'h01, ws, 0);
        wait_end();
        chk("t3_done",   done, 1'b1);
        chk("t3_errclr", error, 1'b0);
        chk("t3_mem0",   dut_mem[0], 32'h00851020);

        // Gap-free versus gappy streaming of the same three words.
        ws = '{rand_word_ok(), rand_word_ok(), rand_word_ok()};
        send_load(8'h03, ws, 0);
        wait_end();
        for (int i = 0; i < 3; i++) begin
            snap[i]    = dut_mem[i];
            dut_mem[i] = '0;
        end
        send_load(8'h03, ws, 3);
        wait_end();
        for (int i = 0; i < 3; i++) chk("t4_gap_mem", dut_mem[i], snap[i]);
        chk("t4_overlap", overlap, 0);

        // Reset after two bytes of word 1, then a clean reload.
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rdy",    byte_ready, 1'b0);
        chk("t5_we",     imem_we,    1'b0);
        chk("t5_cpurst", cpu_reset,  1'b1);
        chk("t5_done",   done,       1'b0);
        chk("t5_count",  count,      '0);
        tick();
        ws = '{32'h8C123456};
        send_load(8'h01, ws, 1);
        wait_end();
        chk("t5_mem0", dut_mem[0], 32'h8C123456);
        chk("t5_done2", done, 1'b1);

        // Unsupported opcode.
        w0 = we_cnt;
        ws = '{32'hFC000000};
        send_load(8'h01, ws, 0);
        wait_end();
`ifdef IMEM_LOADER_OPCHK_EN
        chk("t6_error",  error, 1'b1);
        chk("t6_writes", we_cnt - w0, 0);
        chk("t6_count",  count, '0);
`else
        chk("t6_done",   done, 1'b1);
        chk("t6_mem0",   dut_mem[0], 32'hFC000000);
        chk("t6_count",  count, 7'd1);
`endif

        // Random programs, random headers and gaps.
        for (int it = 0; it < 8; it++) begin
            ws = {};
            if ($urandom_range(5, 0) == 0) begin
                hb = 8'($urandom_range(255, 65));
            end else begin
                hb = 8'($urandom_range(6, 1));
                for (int i = 0; i < int'(hb); i++)
                    ws.push_back(($urandom_range(1, 0) == 1) ? rand_word_ok() : 32'($urandom()));
            end
            send_load(hb, ws, 3);
            wait_end();
            chk("rand_mem", mem_diffs(), 0);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
